demux_dispatcher: RTL

Sequential front-end for the 16-bit 1-to-3 demultiplexer datapath. It accepts a valid/ready word stream, selects the destination channel per word from a 2-bit tag (or round-robin when the tag is 00), and holds each routed word in a one-entry per-channel output register until that channel consumes it. It sits between a single producer and three independent consumers, so the select is sequenced with flow control rather than driven directly by the producer.

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_dispatcher_if.sv | 19 +
 rtl/demux_out_slot.sv | 35 +++
 rtl/demux_dispatcher.sv | 54 +++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: channel codes, round-robin state encoding and default width for demux_dispatcher
package demux_pkg;
  localparam int DEF_W = 16;
  localparam logic [1:0] CH_AUTO = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;
  // States share the channel-code encoding so the pointer doubles as a target code
  typedef enum logic [1:0] {
    RR_CH1 = 2'b01,
    RR_CH2 = 2'b10,
    RR_CH3 = 2'b11
  } rr_e;
endpackage

// File: rtl/demux_dispatcher_if.sv
// demux_dispatcher_if: producer/consumer bundle of demux_dispatcher; cnt exists only with DEMUX_DISP_CNT_EN
interface demux_dispatcher_if import demux_pkg::*; #(parameter int W = DEF_W, parameter int NCH = 3);
  logic [W-1:0]     in_data;
  logic [1:0]       in_dest;
  logic             in_valid;
  logic             in_ready;
  logic [NCH*W-1:0] out_data;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
  logic [1:0]       last_sel;
`ifdef DEMUX_DISP_CNT_EN
  logic [NCH*16-1:0] cnt;
  modport master (output in_data, in_dest, in_valid, out_ready, input in_ready, out_data, out_valid, last_sel, cnt);
  modport slave (input in_data, in_dest, in_valid, out_ready, output in_ready, out_data, out_valid, last_sel, cnt);
`else
  modport master (output in_data, in_dest, in_valid, out_ready, input in_ready, out_data, out_valid, last_sel);
  modport slave (input in_data, in_dest, in_valid, out_ready, output in_ready, out_data, out_valid, last_sel);
`endif
endinterface

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry per-channel output register; delivered-word counter with DEMUX_DISP_CNT_EN
module demux_out_slot import demux_pkg::*; #(parameter int W = DEF_W) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         free
`ifdef DEMUX_DISP_CNT_EN
  ,
  output logic [15:0]  cnt
`endif
);
  assign free = !out_valid || out_ready;
  // A write wins over a drain so a same-cycle drain and refill keeps the slot valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (wr) begin
      out_valid <= 1'b1;
      out_data <= wr_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef DEMUX_DISP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (out_valid && out_ready) cnt <= cnt + 16'd1;
  end
`endif
endmodule

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: valid/ready 1-to-3 word dispatcher, tag-directed or round-robin on tag 00.
// Optional per-channel delivered-word counters with DEMUX_DISP_CNT_EN.
module demux_dispatcher import demux_pkg::*; #(parameter int W = DEF_W, parameter int NCH = 3) (
  input logic clk,
  input logic rst,
  demux_dispatcher_if.slave bus
);
  rr_e rr;
  logic [1:0] tgt;
  logic [1:0] last_sel;
  logic [NCH-1:0] free, wr, ov;
  logic [NCH*W-1:0] od;
  logic acc;
`ifdef DEMUX_DISP_CNT_EN
  logic [NCH*16-1:0] cn;
  assign bus.cnt = cn;
`endif
  assign tgt = bus.in_dest != CH_AUTO ? bus.in_dest : rr;
  assign bus.in_ready = rst || free[tgt - 2'd1];
  assign acc = bus.in_valid && bus.in_ready && !rst;
  assign bus.out_valid = ov;
  assign bus.out_data = od;
  assign bus.last_sel = last_sel;
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_slot
      assign wr[i] = acc && tgt == 2'(i + 1);
      demux_out_slot #(.W(W)) u_slot (
        .clk(clk),
        .rst(rst),
        .wr(wr[i]),
        .wr_data(bus.in_data),
        .out_ready(bus.out_ready[i]),
        .out_valid(ov[i]),
        .out_data(od[i*W +: W]),
        .free(free[i])
`ifdef DEMUX_DISP_CNT_EN
        ,
        .cnt(cn[i*16 +: 16])
`endif
      );
    end
  endgenerate
  // Pointer never skips a full channel: it moves only when its own channel took a word
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= RR_CH1;
      last_sel <= CH_AUTO;
    end else if (acc) begin
      last_sel <= tgt;
      if (bus.in_dest == CH_AUTO) rr <= rr == RR_CH3 ? RR_CH1 : rr_e'(rr + 2'd1);
    end
  end
endmodule
